// File: rtl/mult_pkg.sv
// mult_pkg -- shared constants and types for the sequential multi-word
// multiplier controller.
//
// Contents:
//   DEF_W, DEF_N, DEF_LAT   default word width, words per operand, and
//                           external multiplier latency
//   idx_width(), col_width() index and column widths derived from N
//   DEF_IDX_W, DEF_COL_W    those widths for the default N
//   state_t                 controller FSM state enumeration
package mult_pkg;

    localparam int DEF_W   = 80;
    localparam int DEF_N   = 4;
    localparam int DEF_LAT = 2;

    // Width of a word index 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a partial-product column i+j, which spans 0..2n-2.
    function automatic int col_width(input int n);
        return (n > 1) ? $clog2(2 * n - 1) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_N);
    localparam int DEF_COL_W = col_width(DEF_N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_tag_pipe.sv
// mult_tag_pipe -- fixed-depth delay line that carries a side-band tag
// alongside each request sent to the external multiplier, so the tag
// emerges in the same cycle as the matching product.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset; clears every stage, including
//            the valid bit held in the tag MSB
//   tag_in   tag entering with the request (TW bits)
//   tag_out  tag delayed by LAT cycles (TW bits)
module mult_tag_pipe #(
    parameter int LAT = 2,
    parameter int TW  = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] tag_in,
    output logic [TW-1:0] tag_out
);

    generate
        if (LAT == 0) begin : g_bypass
            assign tag_out = tag_in;
        end else begin : g_pipe
            logic [TW-1:0] stage [LAT];

            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples its predecessor's old value on the same edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < LAT; k++) stage[k] <= '0;
                end else begin
                    stage[0] <= tag_in;
                    for (int k = 1; k < LAT; k++) stage[k] <= stage[k-1];
                end
            end

            assign tag_out = stage[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl -- sequences an (N*W) x (N*W) multiplication through a
// single external W x W multiplier of fixed latency LAT, issuing the N*N
// word products in operand-scanning order (i outer, j inner) and emitting
// each partial product A[i]*B[j] with its column index i+j.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   ld_en/ld_sel      operand word write strobe; ld_sel 0 = A bank, 1 = B bank
//   ld_idx, ld_data   word index and value (accepted only while idle)
//   start             begin a multiplication (accepted only while idle)
//   busy, done        operation in progress / one-cycle completion pulse
//   mul_en, mul_a/b   issue strobe and operands to the external multiplier
//   mul_res           product, valid LAT cycles after its mul_en
//   pp_valid/pp_data  partial-product strobe and value
//   pp_col, pp_last   column i+j and final-product marker
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int N   = DEF_N,
    parameter int LAT = DEF_LAT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_en,
    input  logic                    ld_sel,
    input  logic [idx_width(N)-1:0] ld_idx,
    input  logic [W-1:0]            ld_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    mul_en,
    output logic [W-1:0]            mul_a,
    output logic [W-1:0]            mul_b,
    input  logic [2*W-1:0]          mul_res,
    output logic                    pp_valid,
    output logic [2*W-1:0]          pp_data,
    output logic [col_width(N)-1:0] pp_col,
    output logic                    pp_last
);

    localparam int IDX_W = idx_width(N);
    localparam int COL_W = col_width(N);
    localparam int TAG_W = COL_W + 2;              // {valid, col, last}
    localparam int DRN_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(LAT);

    // ------------------------------------------------------------------
    // Operand banks
    // ------------------------------------------------------------------
    logic [W-1:0] a_bank [N];
    logic [W-1:0] b_bank [N];

    state_t state_q, state_nxt;

    logic wr_en;
    assign wr_en = ld_en && (state_q == ST_IDLE) &&
                   ({1'b0, ld_idx} < (IDX_W + 1)'(N));

    // NOTE: the operand banks are plain storage with no reset; their
    // contents survive rst and are only ever changed by explicit loads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (ld_sel) b_bank[ld_idx] <= ld_data;
            else        a_bank[ld_idx] <= ld_data;
        end
    end

    // A load of word 0 in the same cycle as start must reach the first issue,
    // so the bank write is forwarded around the storage.
    logic [W-1:0] a_word0, b_word0;
    assign a_word0 = (wr_en && !ld_sel && (ld_idx == '0)) ? ld_data : a_bank[0];
    assign b_word0 = (wr_en &&  ld_sel && (ld_idx == '0)) ? ld_data : b_bank[0];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] i_q, j_q, i_nxt, j_nxt;
    logic [DRN_W-1:0] drn_q, drn_nxt;
    logic             issue_last;

    assign issue_last = (i_q == LAST_IDX) && (j_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_nxt;
            i_q     <= i_nxt;
            j_q     <= j_nxt;
            drn_q   <= drn_nxt;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state_q;
        i_nxt     = i_q;
        j_nxt     = j_q;
        drn_nxt   = drn_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ISSUE;
                    i_nxt     = '0;
                    j_nxt     = '0;
                end
            end
            ST_ISSUE: begin
                if (issue_last) begin
                    state_nxt = ST_DRAIN;
                    drn_nxt   = '0;
                end else if (j_q == LAST_IDX) begin
                    j_nxt = '0;
                    i_nxt = i_q + 1'b1;
                end else begin
                    j_nxt = j_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // LAT+1 cycles: the last product needs LAT cycles to return
                // and one more to land in pp_data.
                if (drn_q == LAST_DRN) state_nxt = ST_DONE;
                else                   drn_nxt   = drn_q + 1'b1;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign mul_en = (state_q == ST_ISSUE);

    // ------------------------------------------------------------------
    // Multiplier operands: registered so that, throughout ISSUE, mul_a/mul_b
    // always hold A[i_q]/B[j_q] for the issue currently on the bus.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (state_nxt == ST_ISSUE) begin
            if (state_q == ST_IDLE) begin
                mul_a <= a_word0;
                mul_b <= b_word0;
            end else begin
                mul_a <= a_bank[i_nxt];
                mul_b <= b_bank[j_nxt];
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline and partial-product output register
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] tag_in, tag_out;
    logic [COL_W-1:0] issue_col;

    assign issue_col = COL_W'(i_q) + COL_W'(j_q);
    assign tag_in    = {mul_en, issue_col, mul_en && issue_last};

    mult_tag_pipe #(
        .LAT (LAT),
        .TW  (TAG_W)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    logic             t_valid, t_last;
    logic [COL_W-1:0] t_col;
    assign t_valid = tag_out[TAG_W-1];
    assign t_col   = tag_out[TAG_W-2:1];
    assign t_last  = tag_out[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pp_valid <= 1'b0;
            pp_last  <= 1'b0;
            pp_data  <= '0;
            pp_col   <= '0;
        end else begin
            pp_valid <= t_valid;
            pp_last  <= t_valid && t_last;
            if (t_valid) begin
                pp_data <= mul_res;
                pp_col  <= t_col;
            end
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl -- self-checking bench for mult_seq_ctrl with a
// behavioural LAT-cycle multiplier. Expected cycle timing and values come
// from the operand-scanning order and full-width arithmetic on the operands.
module tb_mult_seq_ctrl;
    import mult_pkg::*;

    localparam int W        = 80;
    localparam int N        = 4;
    localparam int LAT      = 2;
    localparam int IDX_W    = idx_width(N);
    localparam int COL_W    = col_width(N);
    localparam int OPW      = N * W;
    localparam int PW       = 2 * OPW;
    localparam int NN       = N * N;
    localparam int PP_FIRST = LAT + 2;        // cycle of first pp_valid
    localparam int T_DONE   = NN + LAT + 2;   // cycle of done

    logic             clk, rst;
    logic             ld_en, ld_sel, start;
    logic [IDX_W-1:0] ld_idx;
    logic [W-1:0]     ld_data;
    logic             busy, done, mul_en, pp_valid, pp_last;
    logic [W-1:0]     mul_a, mul_b;
    logic [2*W-1:0]   mul_res, pp_data;
    logic [COL_W-1:0] pp_col;

    mult_seq_ctrl #(.W(W), .N(N), .LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (ld_en),
        .ld_sel   (ld_sel),
        .ld_idx   (ld_idx),
        .ld_data  (ld_data),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .mul_en   (mul_en),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_res  (mul_res),
        .pp_valid (pp_valid),
        .pp_data  (pp_data),
        .pp_col   (pp_col),
        .pp_last  (pp_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External multiplier: product of the operands presented LAT cycles ago.
    logic [2*W-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= (2*W)'(mul_a) * (2*W)'(mul_b);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_res = mpipe[LAT-1];

    typedef struct packed {
        logic [N-1:0][W-1:0] a;
        logic [N-1:0][W-1:0] b;
        logic [PW-1:0]       exp_prod;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic checkw(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk_vec(input logic [N-1:0][W-1:0] a, input logic [N-1:0][W-1:0] b);
        vec_t v;
        v.a = a;
        v.b = b;
        v.exp_prod = PW'(a) * PW'(b);
        return v;
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    // Called aligned just after a rising edge; leaves the bench aligned the same way.
    task automatic load_vec(input vec_t v);
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < N; k++) begin
                ld_en   = 1'b1;
                ld_sel  = (s == 1);
                ld_idx  = IDX_W'(k);
                ld_data = (s == 1) ? v.b[k] : v.a[k];
                @(posedge clk); #1;
            end
        end
        ld_en = 1'b0;
    endtask

    // Start an operation in the current cycle (cycle 0) and check every cycle
    // up to done. inj_* give cycles for a spurious start, a load during ISSUE
    // and a reset (-1 = none); fwd_sel loads word 0 of A (0) or B (1) in the
    // start cycle itself.
    task automatic run_op(input vec_t v, input int inj_start, input int inj_load,
                          input int inj_rst, input int fwd_sel);
        logic [PW-1:0] acc;
        int            n_pp;
        bit            aborted;
        acc     = '0;
        n_pp    = 0;
        aborted = 1'b0;
        start   = 1'b1;
        if (fwd_sel >= 0) begin
            ld_en   = 1'b1;
            ld_sel  = (fwd_sel == 1);
            ld_idx  = '0;
            ld_data = (fwd_sel == 1) ? v.b[0] : v.a[0];
        end
        @(negedge clk);
        check1("idle_busy", busy, 1'b0);
        check1("idle_done", done, 1'b0);
        for (int c = 1; c <= T_DONE; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            ld_en = 1'b0;
            rst   = 1'b0;
            if (c == inj_start) start = 1'b1;
            if (c == inj_load) begin
                ld_en   = 1'b1;
                ld_sel  = 1'b0;
                ld_idx  = IDX_W'(N - 1);
                ld_data = ~v.a[N-1];
            end
            if (c == inj_rst) rst = 1'b1;
            @(negedge clk);
            if (inj_rst >= 0 && c > inj_rst) begin
                aborted = 1'b1;
                check1("rst_busy", busy, 1'b0);
                check1("rst_mul_en", mul_en, 1'b0);
                check1("rst_pp_valid", pp_valid, 1'b0);
                check1("rst_done", done, 1'b0);
            end else begin
                check1("busy", busy, 1'b1);
                check1("done", done, c == T_DONE);
                check1("mul_en", mul_en, c <= NN);
                if (c <= NN) begin
                    checkw("mul_a", PW'(mul_a), PW'(v.a[(c-1)/N]));
                    checkw("mul_b", PW'(mul_b), PW'(v.b[(c-1)%N]));
                end
                check1("pp_valid", pp_valid, (c >= PP_FIRST) && (c < PP_FIRST + NN));
                if ((c >= PP_FIRST) && (c < PP_FIRST + NN)) begin
                    int p, i, j;
                    p = c - PP_FIRST;
                    i = p / N;
                    j = p % N;
                    checkw("pp_data", PW'(pp_data), PW'((2*W)'(v.a[i]) * (2*W)'(v.b[j])));
                    checkw("pp_col", PW'(pp_col), PW'(i + j));
                    check1("pp_last", pp_last, p == NN - 1);
                    acc = acc + (PW'(pp_data) << (int'(pp_col) * W));
                    n_pp++;
                end else begin
                    check1("pp_last_idle", pp_last, 1'b0);
                end
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        ld_en = 1'b0;
        rst   = 1'b0;
        if (!aborted) begin
            checkw("full_product", acc, v.exp_prod);
            checkw("pp_count", PW'(n_pp), PW'(NN));
        end
    endtask

    vec_t vecs [8];

    initial begin
        logic [N-1:0][W-1:0] ta, tb;
        vec_t v2;

        // Stimulus table.
        for (int k = 0; k < N; k++) begin
            ta[k] = W'(k + 1);
            tb[k] = W'(1);
        end
        vecs[0] = mk_vec(ta, tb);
        ta = '0;
        ta[0] = 80'h52f766_dbe90cfb52f766;
        vecs[1] = mk_vec(ta, ta);
        vecs[2] = mk_vec('1, '1);
        for (int t = 3; t < 8; t++) begin
            for (int k = 0; k < N; k++) begin
                ta[k] = rnd_word();
                tb[k] = rnd_word();
            end
            vecs[t] = mk_vec(ta, tb);
        end

        rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_sel = 1'b0;
        ld_idx = '0; ld_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);
        check1("reset_mul_en", mul_en, 1'b0);
        check1("reset_pp_valid", pp_valid, 1'b0);
        check1("reset_pp_last", pp_last, 1'b0);
        checkw("reset_pp_data", PW'(pp_data), '0);
        checkw("reset_pp_col", PW'(pp_col), '0);
        checkw("reset_mul_a", PW'(mul_a), '0);
        checkw("reset_mul_b", PW'(mul_b), '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven operations.
        for (int t = 0; t < 8; t++) begin
            load_vec(vecs[t]);
            run_op(vecs[t], -1, -1, -1, -1);
        end

        // Square of a single non-zero word: first partial product is the 160-bit square.
        checkw("square_vec", vecs[1].exp_prod,
               PW'(160'(80'h52f766_dbe90cfb52f766) * 160'(80'h52f766_dbe90cfb52f766)));

        // Spurious start mid-operation is ignored; done stays at its slot.
        load_vec(vecs[3]);
        run_op(vecs[3], 5, -1, -1, -1);

        // Load during ISSUE is ignored, then a back-to-back run on the same
        // (unchanged) banks starts the cycle after done.
        load_vec(vecs[4]);
        run_op(vecs[4], -1, 2, -1, -1);
        run_op(vecs[4], -1, -1, -1, -1);

        // Reset mid-ISSUE aborts cleanly; banks survive for a fresh start.
        load_vec(vecs[5]);
        run_op(vecs[5], -1, -1, 8, -1);
        run_op(vecs[5], -1, -1, -1, -1);

        // Load of word 0 coincident with start is used by the first issue.
        v2 = vecs[6];
        v2.a[0] = ~v2.a[0];
        load_vec(v2);
        run_op(vecs[6], -1, -1, -1, 0);
        v2 = vecs[7];
        v2.b[0] = ~v2.b[0];
        load_vec(v2);
        run_op(vecs[7], -1, -1, -1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 Parameter W, default 80: operand word width in bits.
REQ-002 Parameter N, default 4: words per operand, so operands are N*W bits.
REQ-003 Parameter LAT, default 2: fixed latency of the external W x W multiplier, in cycles from mul_en to mul_res.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 ld_en  in  1  operand word write strobe.
REQ-007 ld_sel  in  1  0 = operand A, 1 = operand B.
REQ-008 ld_idx  in  clog2(N)  word index to write.
REQ-009 ld_data  in  W  word value.
REQ-010 start  in  1  single-cycle request to begin a multiplication.
REQ-011 busy  out  1  high while an operation is in progress.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 mul_en  out  1  issue strobe to the external multiplier.
REQ-014 mul_a, mul_b  out  W each  multiplier operands.
REQ-015 mul_res  in  2W  multiplier product, valid exactly LAT cycles after the matching mul_en.
REQ-016 pp_valid  out  1  partial-product output strobe.
REQ-017 pp_data  out  2W  partial product A[i]*B[j].
REQ-018 pp_col  out  clog2(2N-1)  column index i+j.
REQ-019 pp_last  out  1  marks the final partial product of the operation.

Function
REQ-020 Operands are held in two internal banks, A[0..N-1] and B[0..N-1].
REQ-021 A write takes effect when ld_en=1 and the state is IDLE; ld_en in any other state is ignored.
REQ-022 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-023 In IDLE, start=1 moves the FSM to ISSUE; start in any other state is ignored.
REQ-024 A load and a start in the same IDLE cycle are both accepted, and the new word is used for the issue.
REQ-025 ISSUE lasts exactly N*N cycles, with mul_en=1 in each cycle.
REQ-026 Issue order is operand-scanning: i outer, j inner, both 0..N-1, with mul_a=A[i] and mul_b=B[j].
REQ-027 After the last issue the FSM enters DRAIN, which lasts LAT+1 cycles, then DONE for 1 cycle, then IDLE.
REQ-028 A tag pipeline of depth LAT carries {valid, i+j, last} alongside each issue.
REQ-029 When the tag exits the pipeline, mul_res is registered into pp_data.
REQ-030 pp_valid, pp_col and pp_last appear on the cycle after tag exit, i.e. LAT+1 cycles after the matching mul_en.
REQ-031 pp_valid is high for exactly N*N cycles per operation, and pp_last is high only with the final one.
REQ-032 done=1 only in DONE, which is the cycle immediately after pp_last.
REQ-033 busy=1 in ISSUE, DRAIN and DONE.
REQ-034 Latency from start to done is N*N+LAT+2 cycles; a new start is accepted on the cycle after done.
REQ-035 mul_a, mul_b, pp_data and pp_col hold their last values while mul_en or pp_valid is low; their contents are then don't-care.
REQ-036 pp_col = i+j, computed without overflow in clog2(2N-1) bits.

Reset
REQ-037 rst=1 at any clock edge, including mid-ISSUE or mid-DRAIN, forces IDLE.
REQ-038 Reset clears busy, done, mul_en, pp_valid, pp_last and all tag valids to 0.
REQ-039 mul_res results returning after a reset are discarded.
REQ-040 Reset does not clear the operand banks.
REQ-041 pp_data, pp_col, mul_a and mul_b reset to 0.

Structure
REQ-042 Package mult_pkg holds the W, N and LAT defaults and the FSM state enumeration.
REQ-043 mult_pkg also holds the index-width and column-width constants derived from N.
REQ-044 The tag pipeline is the sub-module mult_tag_pipe, parameterised by LAT and the tag width.

Verification
REQ-045 N=4, LAT=2: load A[k]=k+1 and B[k]=1, start at cycle 0 -> mul_en high in cycles 1..16, pp_valid high in cycles 4..19 with pp_data sequence 1,1,1,1,2,2,...,4, pp_col sequence 0,1,2,3,1,2,3,4,..., pp_last at cycle 19, done at cycle 20, busy high in cycles 1..20.
REQ-046 A[0]=B[0]=80'h52f766_dbe90cfb52f766, all other words 0 -> first pp_data equals the 160-bit square of that value and all other pp_data equal 0.
REQ-047 A ld_en with a changed value during ISSUE -> the operand bank is unchanged and the results equal those of the pre-load operands.
REQ-048 start pulsed again at cycle 5 -> ignored, and done still occurs at cycle 20.
REQ-049 rst asserted at cycle 8 -> the next cycle has busy=0 and pp_valid=0 with no further pp_valid; a fresh start then completes correctly.
REQ-050 Back-to-back operations with start at the cycle after done -> the second operation's done arrives exactly 20 cycles after its start.
